keypad_entry: RTL and testbench

//   Input-side counterpart of the multiplexed 7-seg display path: scans a 4x4 matrix keypad
//   (row strobes out, column sense in), debounces, decodes keys and accumulates decimal

---
 rtl/keypad_entry.sv | 192 +++++++++++++++++++
 tb/tb_keypad_entry.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, key decode and decimal-to-binary entry accumulation.
// Typed digits build an 8-bit value; '#' commits it, '*' clears it, and A-D only strobe.
module keypad_entry #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [7:0] entry,
   output logic [1:0] digit_count,
   output logic [7:0] value,
   output logic       value_valid,
   output logic [3:0] key_code,
   output logic       key_strobe,
   output logic       overflow
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DB_N      = CW'(DEBOUNCE);

   typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESS, S_HELD} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] slot_q;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    entry_q, entry_d;
   logic [1:0]    count_q, count_d;
   logic [7:0]    value_q, value_d;
   logic          vv_q, vv_d;
   logic [3:0]    code_q, code_d;
   logic          strobe_q, strobe_d;
   logic          ovf_q, ovf_d;

   logic          sample;
   logic          is_digit, is_clear, is_enter;
   logic [3:0]    dval;
   logic [11:0]   t;

   function automatic logic [1:0] lowest_low(input logic [3:0] c);
      casez (c)
         4'b???0: lowest_low = 2'd0;
         4'b??01: lowest_low = 2'd1;
         4'b?011: lowest_low = 2'd2;
         default: lowest_low = 2'd3;
      endcase
   endfunction

   assign sample = (slot_q == SLOT_LAST);

   // Key index 4*r+c: digits 1-9 on the 3x3 block, 0 at r3c1, '*' r3c0, '#' r3c2.
   always_comb begin
      is_digit = 1'b0;
      dval     = 4'd0;
      is_clear = ({row_idx_q, col_idx_q} == 4'd12);
      is_enter = ({row_idx_q, col_idx_q} == 4'd14);
      if (row_idx_q != 2'd3 && col_idx_q != 2'd3) begin
         is_digit = 1'b1;
         dval     = {2'b00, row_idx_q} * 4'd3 + {2'b00, col_idx_q} + 4'd1;
      end else if ({row_idx_q, col_idx_q} == 4'd13) begin
         is_digit = 1'b1;
      end
   end

   assign t = {4'd0, entry_q} * 12'd10 + {8'd0, dval};

   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      col_idx_d = col_idx_q;
      cnt_d     = cnt_q;
      entry_d   = entry_q;
      count_d   = count_q;
      value_d   = value_q;
      vv_d      = 1'b0;
      code_d    = code_q;
      strobe_d  = 1'b0;
      ovf_d     = ovf_q;
      case (state_q)
         S_SCAN: begin
            if (sample) begin
               if (col == 4'hF) begin
                  row_idx_d = row_idx_q + 2'd1;
               end else begin
                  col_idx_d = lowest_low(col);
                  cnt_d     = CW'(1);
                  state_d   = (DEBOUNCE == 1) ? S_PRESS : S_DEBOUNCE;
               end
            end
         end
         S_DEBOUNCE: begin
            if (sample) begin
               if (!col[col_idx_q]) begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q + CW'(1) == DB_N) state_d = S_PRESS;
               end else begin
                  state_d   = S_SCAN;
                  row_idx_d = row_idx_q + 2'd1;
               end
            end
         end
         S_PRESS: begin
            strobe_d = 1'b1;
            code_d   = {row_idx_q, col_idx_q};
            cnt_d    = '0;
            state_d  = S_HELD;
            if (is_digit) begin
               if (count_q < 2'd3 && t <= 12'd255) begin
                  entry_d = t[7:0];
                  count_d = count_q + 2'd1;
               end else begin
                  ovf_d = 1'b1;
               end
            end else if (is_enter) begin
               // An empty entry only clears overflow; nothing is committed.
               if (count_q != 2'd0) begin
                  value_d = entry_q;
                  vv_d    = 1'b1;
               end
               entry_d = 8'd0;
               count_d = 2'd0;
               ovf_d   = 1'b0;
            end else if (is_clear) begin
               entry_d = 8'd0;
               count_d = 2'd0;
               ovf_d   = 1'b0;
            end
         end
         S_HELD: begin
            if (sample) begin
               if (col[col_idx_q]) begin
                  if (cnt_q + CW'(1) == DB_N) begin
                     state_d   = S_SCAN;
                     row_idx_d = row_idx_q + 2'd1;
                     cnt_d     = '0;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = S_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_SCAN;
         slot_q    <= '0;
         row_idx_q <= 2'd0;
         col_idx_q <= 2'd0;
         cnt_q     <= '0;
         entry_q   <= 8'd0;
         count_q   <= 2'd0;
         value_q   <= 8'd0;
         vv_q      <= 1'b0;
         code_q    <= 4'd0;
         strobe_q  <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= sample ? '0 : slot_q + SW'(1);
         row_idx_q <= row_idx_d;
         col_idx_q <= col_idx_d;
         cnt_q     <= cnt_d;
         entry_q   <= entry_d;
         count_q   <= count_d;
         value_q   <= value_d;
         vv_q      <= vv_d;
         code_q    <= code_d;
         strobe_q  <= strobe_d;
         ovf_q     <= ovf_d;
      end
   end

   assign row         = ~(4'b0001 << row_idx_q);
   assign entry       = entry_q;
   assign digit_count = count_q;
   assign value       = value_q;
   assign value_valid = vv_q;
   assign key_code    = code_q;
   assign key_strobe  = strobe_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a switch-matrix model closes one row/column contact
// and each step compares DUT outputs against hand-computed values.
module tb_keypad_entry;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [7:0] entry;
   logic [1:0] digit_count;
   logic [7:0] value;
   logic       value_valid;
   logic [3:0] key_code;
   logic       key_strobe;
   logic       overflow;

   logic       key_dn = 1'b0;
   logic [1:0] key_r = 2'd0;
   logic [1:0] key_c = 2'd0;

   int vectors = 0;
   int miscompares = 0;
   int n_strobe = 0;
   int n_vv = 0;
   int s0, v0;

   keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col), .entry(entry),
      .digit_count(digit_count), .value(value), .value_valid(value_valid),
      .key_code(key_code), .key_strobe(key_strobe), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always_comb begin
      col = 4'hF;
      if (key_dn && row[key_r] == 1'b0) col[key_c] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_strobe) n_strobe++;
      if (value_valid) n_vv++;
   end

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c, input bit rel);
      bit got;
      got = 1'b0;
      key_r = r;
      key_c = c;
      key_dn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (key_strobe === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      chk("strobe_seen", {11'd0, got}, 12'd1);
      if (got) chk("key_code", {8'd0, key_code}, {8'd0, r, c});
      if (rel) begin
         repeat (8) @(negedge clk);
         key_dn = 1'b0;
         repeat (40) @(negedge clk);
      end
   endtask

   initial begin
      // Reset state, then idle row scan
      repeat (3) @(negedge clk);
      chk("rst_row", {8'd0, row}, 12'hE);
      chk("rst_entry", {4'd0, entry}, 12'd0);
      chk("rst_count", {10'd0, digit_count}, 12'd0);
      chk("rst_value", {4'd0, value}, 12'd0);
      chk("rst_vv", {11'd0, value_valid}, 12'd0);
      chk("rst_code", {8'd0, key_code}, 12'd0);
      chk("rst_strobe", {11'd0, key_strobe}, 12'd0);
      chk("rst_ovf", {11'd0, overflow}, 12'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("row_hold", {8'd0, row}, 12'hE);
      @(negedge clk);
      chk("row1", {8'd0, row}, 12'hD);
      repeat (4) @(negedge clk);
      chk("row2", {8'd0, row}, 12'hB);
      repeat (4) @(negedge clk);
      chk("row3", {8'd0, row}, 12'h7);
      repeat (4) @(negedge clk);
      chk("row_wrap", {8'd0, row}, 12'hE);
      chk("idle_strobes", 12'(n_strobe), 12'd0);

      // 1 2 3 #
      press(2'd0, 2'd0, 1'b1);
      chk("e1", {4'd0, entry}, 12'd1);
      press(2'd0, 2'd1, 1'b1);
      chk("e12", {4'd0, entry}, 12'd12);
      press(2'd0, 2'd2, 1'b1);
      chk("e123", {4'd0, entry}, 12'd123);
      chk("cnt3", {10'd0, digit_count}, 12'd3);
      v0 = n_vv;
      press(2'd3, 2'd2, 1'b1);
      chk("val123", {4'd0, value}, 12'd123);
      chk("vv_one", 12'(n_vv - v0), 12'd1);
      chk("enter_clr", {4'd0, entry}, 12'd0);
      chk("enter_cnt", {10'd0, digit_count}, 12'd0);

      // 2 5 6 -> 256 rejected, then '*'
      press(2'd0, 2'd1, 1'b1);
      press(2'd1, 2'd1, 1'b1);
      press(2'd1, 2'd2, 1'b1);
      chk("e25", {4'd0, entry}, 12'd25);
      chk("cnt2", {10'd0, digit_count}, 12'd2);
      chk("ovf256", {11'd0, overflow}, 12'd1);
      press(2'd3, 2'd0, 1'b1);
      chk("star_e", {4'd0, entry}, 12'd0);
      chk("star_cnt", {10'd0, digit_count}, 12'd0);
      chk("star_ovf", {11'd0, overflow}, 12'd0);
      chk("star_val", {4'd0, value}, 12'd123);

      // 0 0 7 then a fourth digit, then '#'
      press(2'd3, 2'd1, 1'b1);
      press(2'd3, 2'd1, 1'b1);
      press(2'd2, 2'd0, 1'b1);
      chk("e007", {4'd0, entry}, 12'd7);
      chk("cnt007", {10'd0, digit_count}, 12'd3);
      press(2'd0, 2'd0, 1'b1);
      chk("e4th", {4'd0, entry}, 12'd7);
      chk("ovf4th", {11'd0, overflow}, 12'd1);
      v0 = n_vv;
      press(2'd3, 2'd2, 1'b1);
      chk("val7", {4'd0, value}, 12'd7);
      chk("vv7", 12'(n_vv - v0), 12'd1);
      chk("ovf_hash", {11'd0, overflow}, 12'd0);
      v0 = n_vv;
      press(2'd3, 2'd2, 1'b1);
      chk("empty_vv", 12'(n_vv - v0), 12'd0);
      chk("empty_val", {4'd0, value}, 12'd7);
      press(2'd0, 2'd3, 1'b1);
      chk("keyA_e", {4'd0, entry}, 12'd0);

      // Bounce: '5' low for a single sample
      s0 = n_strobe;
      for (int i = 0; i < 40 && row != 4'hE; i++) @(negedge clk);
      for (int i = 0; i < 40 && row != 4'hD; i++) @(negedge clk);
      chk("bnc_sync", {8'd0, row}, 12'hD);
      key_r = 2'd1;
      key_c = 2'd1;
      key_dn = 1'b1;
      repeat (4) @(negedge clk);
      chk("bnc_held", {8'd0, row}, 12'hD);
      key_dn = 1'b0;
      repeat (4) @(negedge clk);
      chk("bnc_adv", {8'd0, row}, 12'hB);
      repeat (20) @(negedge clk);
      chk("bnc_nostb", 12'(n_strobe - s0), 12'd0);

      // Hold '5' for 50 samples
      s0 = n_strobe;
      press(2'd1, 2'd1, 1'b0);
      repeat (200) @(negedge clk);
      key_dn = 1'b0;
      repeat (40) @(negedge clk);
      chk("hold_once", 12'(n_strobe - s0), 12'd1);
      chk("hold_e", {4'd0, entry}, 12'd5);

      // Reset while HELD with entry 42
      press(2'd3, 2'd0, 1'b1);
      press(2'd1, 2'd0, 1'b1);
      press(2'd0, 2'd1, 1'b0);
      repeat (10) @(negedge clk);
      chk("e42", {4'd0, entry}, 12'd42);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_row", {8'd0, row}, 12'hE);
      chk("mid_entry", {4'd0, entry}, 12'd0);
      chk("mid_cnt", {10'd0, digit_count}, 12'd0);
      chk("mid_value", {4'd0, value}, 12'd0);
      chk("mid_code", {8'd0, key_code}, 12'd0);
      key_dn = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_scan", {8'd0, row}, 12'hD);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
